// File: rtl/decode_stage.sv
// decode_stage: RV32I decode stage with write-through register file and a stallable,
// flushable ID/EX pipeline register.
module decode_stage #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     InstrD,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] PCplus4D,
  input  logic            RegWriteW,
  input  logic [4:0]      RdW,
  input  logic [XLEN-1:0] ResultW,
  input  logic            StallE,
  input  logic            FlushE,
  output logic [XLEN-1:0] RD1E,
  output logic [XLEN-1:0] RD2E,
  output logic [XLEN-1:0] ImmExtE,
  output logic [XLEN-1:0] PCE,
  output logic [XLEN-1:0] PCPlus4E,
  output logic [4:0]      Rs1E,
  output logic [4:0]      Rs2E,
  output logic [4:0]      RdE,
  output logic [2:0]      Funct3E,
  output logic            RegWriteE,
  output logic            MemWriteE,
  output logic            JumpE,
  output logic            BranchE,
  output logic            ALUSrcE,
  output logic            SrcAPCE,
  output logic            IllegalE,
  output logic [1:0]      ResultSrcE,
  output logic [3:0]      ALUControlE
);
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                         OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;
  localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_AND = 4'd2, A_OR = 4'd3, A_XOR = 4'd4,
                         A_SLT = 4'd5, A_SLTU = 4'd6, A_SLL = 4'd7, A_SRL = 4'd8, A_SRA = 4'd9;
  logic [6:0] op;
  logic [2:0] f3;
  logic b30;
  logic reg_write, mem_write, jump, branch, alu_src, src_a_pc, illegal, use_rs1, use_rs2;
  logic [1:0] result_src;
  logic [3:0] alu_op, alu_rr, alu_br;
  logic [4:0] rs1, rs2, rd;
  logic [XLEN-1:0] imm, i_imm, s_imm, b_imm, j_imm, u_imm, rd1, rd2;
  logic [XLEN-1:0] rf [32];
  assign op = InstrD[6:0];
  assign f3 = InstrD[14:12];
  assign b30 = InstrD[30];
  assign i_imm = {{20{InstrD[31]}}, InstrD[31:20]};
  assign s_imm = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
  assign b_imm = {{19{InstrD[31]}}, InstrD[31], InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
  assign j_imm = {{11{InstrD[31]}}, InstrD[31], InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
  assign u_imm = {InstrD[31:12], 12'b0};
  // bit 30 only distinguishes sra/srl here; sub is selected separately for R-type
  assign alu_rr = f3 == 3'b000 ? A_ADD : f3 == 3'b001 ? A_SLL : f3 == 3'b010 ? A_SLT :
                  f3 == 3'b011 ? A_SLTU : f3 == 3'b100 ? A_XOR :
                  f3 == 3'b101 ? (b30 ? A_SRA : A_SRL) : f3 == 3'b110 ? A_OR : A_AND;
  assign alu_br = f3[2] ? (f3[1] ? A_SLTU : A_SLT) : A_SUB;
  always_comb begin
    reg_write = 1'b0;
    mem_write = 1'b0;
    jump = 1'b0;
    branch = 1'b0;
    alu_src = 1'b0;
    src_a_pc = 1'b0;
    illegal = 1'b0;
    result_src = 2'b00;
    alu_op = A_ADD;
    imm = i_imm;
    use_rs1 = 1'b1;
    use_rs2 = 1'b0;
    case (op)
      OP_R: begin
        reg_write = 1'b1;
        use_rs2 = 1'b1;
        alu_op = (f3 == 3'b000 && b30) ? A_SUB : alu_rr;
      end
      OP_I: begin
        reg_write = 1'b1;
        alu_src = 1'b1;
        alu_op = alu_rr;
      end
      OP_LD: begin
        reg_write = 1'b1;
        alu_src = 1'b1;
        result_src = 2'b01;
      end
      OP_ST: begin
        mem_write = 1'b1;
        alu_src = 1'b1;
        use_rs2 = 1'b1;
        imm = s_imm;
      end
      OP_BR: begin
        branch = 1'b1;
        use_rs2 = 1'b1;
        alu_op = alu_br;
        imm = b_imm;
      end
      OP_JAL: begin
        reg_write = 1'b1;
        jump = 1'b1;
        src_a_pc = 1'b1;
        result_src = 2'b10;
        use_rs1 = 1'b0;
        imm = j_imm;
      end
      OP_JALR: begin
        reg_write = 1'b1;
        jump = 1'b1;
        alu_src = 1'b1;
        result_src = 2'b10;
      end
      OP_LUI: begin
        reg_write = 1'b1;
        alu_src = 1'b1;
        use_rs1 = 1'b0;
        imm = u_imm;
      end
      OP_AUIPC: begin
        reg_write = 1'b1;
        alu_src = 1'b1;
        src_a_pc = 1'b1;
        use_rs1 = 1'b0;
        imm = u_imm;
      end
      default: begin
        illegal = 1'b1;
        use_rs1 = 1'b0;
      end
    endcase
  end
  assign rs1 = use_rs1 ? InstrD[19:15] : 5'd0;
  assign rs2 = use_rs2 ? InstrD[24:20] : 5'd0;
  assign rd = illegal ? 5'd0 : InstrD[11:7];
  // write-through so a same-cycle W-stage write is seen by this read
  assign rd1 = rs1 == 5'd0 ? '0 : (RegWriteW && RdW == rs1) ? ResultW : rf[rs1];
  assign rd2 = rs2 == 5'd0 ? '0 : (RegWriteW && RdW == rs2) ? ResultW : rf[rs2];
  always_ff @(posedge clk or negedge rst)
    if (!rst) for (int i = 0; i < 32; i++) rf[i] <= '0;
    else if (RegWriteW && RdW != 5'd0) rf[RdW] <= ResultW;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      RD1E <= '0;
      RD2E <= '0;
      ImmExtE <= '0;
      PCE <= RESET_PC;
      PCPlus4E <= RESET_PC + XLEN'(4);
      Rs1E <= '0;
      Rs2E <= '0;
      RdE <= '0;
      Funct3E <= '0;
      RegWriteE <= 1'b0;
      MemWriteE <= 1'b0;
      JumpE <= 1'b0;
      BranchE <= 1'b0;
      ALUSrcE <= 1'b0;
      SrcAPCE <= 1'b0;
      IllegalE <= 1'b0;
      ResultSrcE <= '0;
      ALUControlE <= '0;
    end else if (FlushE) begin
      RegWriteE <= 1'b0;
      MemWriteE <= 1'b0;
      JumpE <= 1'b0;
      BranchE <= 1'b0;
      IllegalE <= 1'b0;
      Rs1E <= '0;
      Rs2E <= '0;
      RdE <= '0;
    end else if (!StallE) begin
      RD1E <= rd1;
      RD2E <= rd2;
      ImmExtE <= imm;
      PCE <= PCD;
      PCPlus4E <= PCplus4D;
      Rs1E <= rs1;
      Rs2E <= rs2;
      RdE <= rd;
      Funct3E <= f3;
      RegWriteE <= reg_write;
      MemWriteE <= mem_write;
      JumpE <= jump;
      BranchE <= branch;
      ALUSrcE <= alu_src;
      SrcAPCE <= src_a_pc;
      IllegalE <= illegal;
      ResultSrcE <= result_src;
      ALUControlE <= alu_op;
    end
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: randomized decode_stage bench against a spec-level reference model.
module tb_decode_stage;
  logic clk = 1'b0, rst = 1'b0;
  logic [31:0] InstrD = '0, PCD = '0, PCplus4D = '0, ResultW = '0;
  logic RegWriteW = 1'b0, StallE = 1'b0, FlushE = 1'b0;
  logic [4:0] RdW = '0;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [4:0] Rs1E, Rs2E, RdE;
  logic [2:0] Funct3E;
  logic RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, SrcAPCE, IllegalE;
  logic [1:0] ResultSrcE;
  logic [3:0] ALUControlE;
  int n_chk = 0, n_err = 0;
  decode_stage dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCplus4D(PCplus4D),
    .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW), .StallE(StallE), .FlushE(FlushE),
    .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .Funct3E(Funct3E), .RegWriteE(RegWriteE),
    .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE), .ALUSrcE(ALUSrcE),
    .SrcAPCE(SrcAPCE), .IllegalE(IllegalE), .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] rd1, rd2, imm, pc, pc4;
    logic [4:0] rs1, rs2, rd;
    logic [2:0] f3;
    logic rw, mw, j, b, as, sp, il;
    logic [1:0] rs;
    logic [3:0] alu;
    bit full, c_rd, c_imm, c_rd1, c_rd2;
  } exp_t;
  logic [31:0] regs [32];
  exp_t e;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t instr=%h)", tag, got, exp, $time, InstrD);
    end
  endtask
  function automatic logic [31:0] rdreg(input logic [4:0] a);
    if (a == 0) return 0;
    if (RegWriteW && RdW == a) return ResultW;
    return regs[a];
  endfunction
  function automatic exp_t reset_exp();
    exp_t r;
    r = '{default: '0};
    r.pc4 = 32'd4;
    r.full = 1; r.c_rd = 1; r.c_imm = 1; r.c_rd1 = 1; r.c_rd2 = 1;
    return r;
  endfunction
  function automatic logic [3:0] alu_of(input logic [2:0] f, input bit sub, input bit sra);
    case (f)
      0: return sub ? 4'd1 : 4'd0;
      1: return 4'd7;
      2: return 4'd5;
      3: return 4'd6;
      4: return 4'd4;
      5: return sra ? 4'd9 : 4'd8;
      6: return 4'd3;
      default: return 4'd2;
    endcase
  endfunction
  function automatic exp_t model(input logic [31:0] i, input logic [31:0] pc, input logic [31:0] pc4);
    exp_t r;
    logic [31:0] ii, si, bi, ji, ui;
    r = '{default: '0};
    ii = 32'($signed(i) >>> 20);
    si = (ii & ~32'h1f) | 32'(i[11:7]);
    bi = (32'($signed(i) >>> 19) & 32'hFFFFF000) | (32'(i[7]) << 11) | (32'(i[30:25]) << 5) | (32'(i[11:8]) << 1);
    ji = (32'($signed(i) >>> 11) & 32'hFFF00000) | (32'(i[19:12]) << 12) | (32'(i[20]) << 11) | (32'(i[30:21]) << 1);
    ui = i & 32'hFFFFF000;
    r.full = 1; r.pc = pc; r.pc4 = pc4; r.f3 = i[14:12];
    r.rs1 = i[19:15]; r.rs2 = i[24:20]; r.rd = i[11:7];
    r.c_rd = 1; r.c_imm = 1; r.c_rd1 = 1; r.c_rd2 = 0;
    case (i[6:0])
      7'b0110011: begin r.rw = 1; r.alu = alu_of(i[14:12], i[30], i[30]); r.c_imm = 0; r.c_rd2 = 1; end
      7'b0010011: begin r.rw = 1; r.as = 1; r.imm = ii; r.alu = alu_of(i[14:12], 0, i[30]); r.rs2 = 0; end
      7'b0000011: begin r.rw = 1; r.as = 1; r.rs = 1; r.imm = ii; r.rs2 = 0; end
      7'b0100011: begin r.mw = 1; r.as = 1; r.imm = si; r.c_rd = 0; r.c_rd2 = 1; end
      7'b1100011: begin
        r.b = 1; r.imm = bi; r.c_rd = 0; r.c_rd2 = 1;
        r.alu = i[14:13] == 2'b00 ? 4'd1 : i[14:13] == 2'b10 ? 4'd5 : 4'd6;
      end
      7'b1101111: begin r.rw = 1; r.j = 1; r.sp = 1; r.rs = 2; r.imm = ji; r.rs1 = 0; r.rs2 = 0; r.c_rd1 = 0; end
      7'b1100111: begin r.rw = 1; r.j = 1; r.as = 1; r.rs = 2; r.imm = ii; r.rs2 = 0; end
      7'b0110111: begin r.rw = 1; r.as = 1; r.imm = ui; r.rs1 = 0; r.rs2 = 0; end
      7'b0010111: begin r.rw = 1; r.as = 1; r.sp = 1; r.imm = ui; r.rs1 = 0; r.rs2 = 0; r.c_rd1 = 0; end
      default: begin r.il = 1; r.c_rd = 0; r.c_imm = 0; r.c_rd1 = 0; r.full = 0; end
    endcase
    r.rd1 = rdreg(r.rs1);
    r.rd2 = rdreg(r.rs2);
    return r;
  endfunction
  task automatic compare(input exp_t x);
    chk("RegWriteE", 32'(RegWriteE), 32'(x.rw));
    chk("MemWriteE", 32'(MemWriteE), 32'(x.mw));
    chk("JumpE", 32'(JumpE), 32'(x.j));
    chk("BranchE", 32'(BranchE), 32'(x.b));
    chk("IllegalE", 32'(IllegalE), 32'(x.il));
    if (x.il) begin
      chk("ALUSrcE", 32'(ALUSrcE), 0);
      chk("SrcAPCE", 32'(SrcAPCE), 0);
      chk("ResultSrcE", 32'(ResultSrcE), 0);
      chk("ALUControlE", 32'(ALUControlE), 0);
    end
    if (!x.full && !x.il) begin
      chk("Rs1E", 32'(Rs1E), 32'(x.rs1));
      chk("Rs2E", 32'(Rs2E), 32'(x.rs2));
      chk("RdE", 32'(RdE), 32'(x.rd));
    end
    if (x.full) begin
      chk("ALUSrcE", 32'(ALUSrcE), 32'(x.as));
      chk("SrcAPCE", 32'(SrcAPCE), 32'(x.sp));
      chk("ResultSrcE", 32'(ResultSrcE), 32'(x.rs));
      chk("ALUControlE", 32'(ALUControlE), 32'(x.alu));
      chk("Funct3E", 32'(Funct3E), 32'(x.f3));
      chk("PCE", PCE, x.pc);
      chk("PCPlus4E", PCPlus4E, x.pc4);
      chk("Rs1E", 32'(Rs1E), 32'(x.rs1));
      chk("Rs2E", 32'(Rs2E), 32'(x.rs2));
      if (x.c_rd) chk("RdE", 32'(RdE), 32'(x.rd));
      if (x.c_imm) chk("ImmExtE", ImmExtE, x.imm);
      if (x.c_rd1) chk("RD1E", RD1E, x.rd1);
      if (x.c_rd2) chk("RD2E", RD2E, x.rd2);
    end
  endtask
  task automatic step(input logic [31:0] instr, input logic rww, input logic [4:0] rdw,
                      input logic [31:0] resw, input logic st, input logic fl);
    logic [31:0] pc;
    pc = {$urandom_range(0, 32'h3FFFFFFF), 2'b00};
    InstrD = instr; PCD = pc; PCplus4D = pc + 4;
    RegWriteW = rww; RdW = rdw; ResultW = resw; StallE = st; FlushE = fl;
    #1;
    if (fl) begin
      e.rw = 0; e.mw = 0; e.j = 0; e.b = 0; e.il = 0;
      e.rs1 = 0; e.rs2 = 0; e.rd = 0; e.full = 0;
    end else if (!st) e = model(instr, pc, pc + 4);
    @(posedge clk);
    if (rww && rdw != 0) regs[rdw] = resw;
    #1 compare(e);
    @(negedge clk);
  endtask
  task automatic reset_mid();
    @(posedge clk);
    #3 rst = 1'b0;
    #1 compare(reset_exp());
    for (int k = 0; k < 32; k++) regs[k] = 0;
    e = reset_exp();
    @(posedge clk);
    #1 compare(e);
    @(negedge clk);
    rst = 1'b1;
    StallE = 0; FlushE = 0;
  endtask
  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [9];
    logic [31:0] i;
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
    i = $urandom;
    if ($urandom_range(0, 9) == 0) begin
      if (i[6:0] == 7'b0110011) i[6:0] = 7'b1111111;
      return i;
    end
    i[6:0] = ops[$urandom_range(0, 8)];
    if (i[6:0] == 7'b1100011 && i[14:13] == 2'b01) i[13] = 1'b0;
    return i;
  endfunction
  initial begin
    for (int k = 0; k < 32; k++) regs[k] = 0;
    e = reset_exp();
    #23 compare(e);
    @(negedge clk);
    rst = 1'b1;
    step(32'h00500093, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    chk("addi_imm", ImmExtE, 32'd5);
    chk("addi_rd", 32'(RdE), 32'd1);
    step(32'h00018233, 1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 1'b0);
    chk("bypass_rd1", RD1E, 32'hDEADBEEF);
    step(32'h00028333, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    chk("x5_after_reset", RD1E, 32'h0);
    step(32'h00000233, 1'b1, 5'd0, 32'h12345678, 1'b0, 1'b0);
    chk("x0_write_bypass", RD1E, 32'h0);
    step(32'h00000233, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    chk("x0_stays_zero", RD1E, 32'h0);
    step(32'h00A00093, 1'b1, 5'd1, 32'h11, 1'b0, 1'b0);
    step(32'hFE208CE3, 1'b1, 5'd2, 32'h22, 1'b0, 1'b0);
    chk("beq_imm", ImmExtE, 32'hFFFFFFF8);
    chk("beq_alu", 32'(ALUControlE), 32'd1);
    chk("beq_rd2_bypass", RD2E, 32'h22);
    step(32'h00018233, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    step(32'hFFFFFFFF, 1'b1, 5'd7, 32'h77, 1'b1, 1'b0);
    step(32'h12345037, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    chk("stall_hold_rd1", RD1E, 32'hDEADBEEF);
    step(32'h00500093, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1);
    step(32'hFFFFFFFF, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    chk("illegal", 32'(IllegalE), 32'd1);
    step(32'h00038433, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    chk("stall_write_x7", RD1E, 32'h77);
    StallE = 1'b1;
    reset_mid();
    step(32'h00038433, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    chk("x7_cleared", RD1E, 32'h0);
    for (int n = 0; n < 600; n++) begin
      if (n == 300) begin
        FlushE = 1'b1;
        reset_mid();
      end
      step(rand_instr(), 1'($urandom_range(0, 1)), 5'($urandom), $urandom,
           $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 10);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
